gpio_serial_loader: RTL



---
 rtl/gpio_serial_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/gpio_serial_loader.sv
// Loads per-GPIO configuration words into the two user-area GPIO serial chains.
// Optional macro GPIO_LOADER_BITBANG_EN adds direct software control of the chain pins while idle.
//
// state    | meaning
// IDLE     | waiting for xfer_start
// FETCH1   | read chain-1 word for step k (addr cycle, then latch cycle)
// FETCH2   | read chain-2 word for step k (addr cycle, then latch cycle)
// SHIFT_LO | serial_clock low, current bit presented
// SHIFT_HI | serial_clock high, bit held stable
// LOAD     | serial_load strobe
// DONE     | one-cycle completion pulse
module gpio_serial_loader #(
    parameter int NUM_IO_1 = 19,
    parameter int NUM_IO_2 = 19,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    input  logic                xfer_start,
    output logic [5:0]          cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_data,
`ifdef GPIO_LOADER_BITBANG_EN
    input  logic                bitbang_en,
    input  logic [4:0]          bitbang_ctrl,
`endif
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_resetn,
    output logic                serial_data_1,
    output logic                serial_data_2
);

    localparam int NSTEP = (NUM_IO_1 > NUM_IO_2) ? NUM_IO_1 : NUM_IO_2;
    localparam int KW    = $clog2(NSTEP + 1);
    localparam int BW    = $clog2(CFG_BITS + 1);
    localparam int TW    = $clog2(CLK_DIV + 2);

    localparam logic [KW-1:0] LAST_K    = KW'(NSTEP - 1);
    localparam logic [TW-1:0] FETCH_LEN = TW'(1);
    localparam logic [TW-1:0] HOLD_LEN  = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(CFG_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH1,
        FETCH2,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TW-1:0]       tmr;
    logic [BW-1:0]       bit_cnt;
    logic [KW-1:0]       k;
    logic [CFG_BITS-1:0] word_1;
    logic [CFG_BITS-1:0] sr_1;
    logic [CFG_BITS-1:0] sr_2;
    logic                resetn_q;
    logic                tmr_zero;
    logic                has_1;
    logic                has_2;
    logic                start_ok;

    assign tmr_zero = (tmr == '0);
    assign has_1    = (k < KW'(NUM_IO_1));
    assign has_2    = (k < KW'(NUM_IO_2));

`ifdef GPIO_LOADER_BITBANG_EN
    assign start_ok = xfer_start && !bitbang_en;
`else
    assign start_ok = xfer_start;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_ok) state_nxt = FETCH1;
            FETCH1:   if (tmr_zero) state_nxt = FETCH2;
            FETCH2:   if (tmr_zero) state_nxt = SHIFT_LO;
            SHIFT_LO: if (tmr_zero) state_nxt = SHIFT_HI;
            SHIFT_HI: begin
                if (tmr_zero) begin
                    if (bit_cnt != '0)    state_nxt = SHIFT_LO;
                    else if (k == LAST_K) state_nxt = LOAD;
                    else                  state_nxt = FETCH1;
                end
            end
            LOAD:     if (tmr_zero) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_addr = '0;
        if (state == FETCH1 && has_1)
            cfg_addr = 6'(NUM_IO_1 - 1) - 6'(k);
        else if (state == FETCH2 && has_2)
            cfg_addr = 6'(38 - NUM_IO_2) + 6'(k);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state    <= IDLE;
            tmr      <= '0;
            bit_cnt  <= '0;
            k        <= '0;
            word_1   <= '0;
            sr_1     <= '0;
            sr_2     <= '0;
            resetn_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            resetn_q <= 1'b1;

            if (state_nxt != state)
                tmr <= (state_nxt == FETCH1 || state_nxt == FETCH2) ? FETCH_LEN : HOLD_LEN;
            else if (!tmr_zero)
                tmr <= tmr - TW'(1);

            if (state == IDLE && start_ok)
                k <= '0;

            if (state == FETCH1 && tmr_zero)
                word_1 <= has_1 ? cfg_data : '0;

            // Both shifters load together so the two chains stay bit-aligned.
            if (state == FETCH2 && tmr_zero) begin
                sr_1    <= word_1;
                sr_2    <= has_2 ? cfg_data : '0;
                bit_cnt <= LAST_BIT;
            end

            if (state == SHIFT_HI && tmr_zero) begin
                if (bit_cnt != '0) begin
                    sr_1    <= sr_1 << 1;
                    sr_2    <= sr_2 << 1;
                    bit_cnt <= bit_cnt - BW'(1);
                end else if (k != LAST_K) begin
                    k <= k + KW'(1);
                end
            end
        end
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

`ifdef GPIO_LOADER_BITBANG_EN
    logic bb_active;
    assign bb_active     = bitbang_en && (state == IDLE) && wb_rstn_i;
    assign serial_resetn = bb_active ? bitbang_ctrl[0] : resetn_q;
    assign serial_load   = bb_active ? bitbang_ctrl[1] : (state == LOAD);
    assign serial_clock  = bb_active ? bitbang_ctrl[2] : (state == SHIFT_HI);
    assign serial_data_1 = bb_active ? bitbang_ctrl[3] : sr_1[CFG_BITS-1];
    assign serial_data_2 = bb_active ? bitbang_ctrl[4] : sr_2[CFG_BITS-1];
`else
    assign serial_resetn = resetn_q;
    assign serial_load   = (state == LOAD);
    assign serial_clock  = (state == SHIFT_HI);
    assign serial_data_1 = sr_1[CFG_BITS-1];
    assign serial_data_2 = sr_2[CFG_BITS-1];
`endif

endmodule
